cache_mem_arbiter: RTL and testbench

- Shares the single main-memory port between the I-cache refill path and the D-cache refill/write-back path of RV32Core.
- Grants one requester per cache-line burst and sequences the LINE_WORDS word beats to memory.
- Returns each beat to the owner and pulses done at burst end.
- Keeps a saturating conflict counter for the performance benches.

---
 rtl/cache_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares the main-memory port between I-cache refills and D-cache refills/write-backs.
// One requester owns the port for a whole cache-line burst of LINE_WORDS beats.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 8,
    localparam int unsigned BEAT_W    = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic [31:0]       rdata,
    output logic [BEAT_W-1:0] beat,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       conflict_cnt
);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state_q, state_n;
    logic              owner_d_q, owner_d_n;  // 1: D-cache owns the burst
    logic              last_d_q, last_d_n;    // 1: last grant went to D
    logic              we_q, we_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [BEAT_W-1:0] beat_q, beat_n;
    logic [31:0]       cnt_q, cnt_n;
    logic              pick_d;
    logic              rd_beat;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_n;
            owner_d_q <= owner_d_n;
            last_d_q  <= last_d_n;
            we_q      <= we_n;
            base_q    <= base_n;
            beat_q    <= beat_n;
            cnt_q     <= cnt_n;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_n   = state_q;
        owner_d_n = owner_d_q;
        last_d_n  = last_d_q;
        we_n      = we_q;
        base_n    = base_q;
        beat_n    = beat_q;
        cnt_n     = cnt_q;
        pick_d    = 1'b0;
        rd_beat   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        rdata     = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time gets the line
                pick_d = d_req && (!i_req || !last_d_q);
                if (i_req && d_req && (cnt_q != '1)) begin
                    cnt_n = cnt_q + 32'd1;
                end
                if (i_req || d_req) begin
                    state_n   = BURST;
                    owner_d_n = pick_d;
                    last_d_n  = pick_d;
                    we_n      = pick_d && d_we;
                    base_n    = (pick_d ? d_addr : i_addr) & LINE_MASK;
                    beat_n    = '0;
                end
            end
            BURST: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_q | (ADDR_W'(beat_q) << 2);
                mem_wdata = we_q ? d_wdata : 32'd0;
                rd_beat   = mem_ack && !we_q;
                i_rvalid  = rd_beat && !owner_d_q;
                d_rvalid  = rd_beat && owner_d_q;
                rdata     = rd_beat ? mem_rdata : 32'd0;
                if (mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        state_n = DONE;
                        beat_n  = '0;
                    end else begin
                        beat_n = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                i_done  = !owner_d_q;
                d_done  = owner_d_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign beat         = beat_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a transaction-level reference model is
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_cache_mem_arbiter;
    localparam int unsigned LW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, conflict_cnt;
    logic [2:0]  beat;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(32), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_done(d_done), .rdata(rdata), .beat(beat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .conflict_cnt(conflict_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 line transfer, 2 completion cycle
    int              m_phase, m_beat;
    bit              m_own_d, m_last_d, m_we;
    logic [31:0]     m_base;
    longint unsigned m_cnt;

    int          ack_mode = 0;
    bit          ack_tog  = 1'b0;
    int          cyc_n    = 0;
    logic [31:0] wb_line [LW];

    bit          s_mem_req, s_mem_ack, s_i_rvalid, s_d_rvalid, s_i_done, s_d_done;
    logic [31:0] s_mem_addr, s_mem_wdata, s_cnt;
    int          s_beat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_phase = 0; m_beat = 0; m_last_d = 1'b0; m_own_d = 1'b0;
            m_we = 1'b0; m_base = '0; m_cnt = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (i_req && d_req && m_cnt < 64'hFFFF_FFFF) m_cnt++;
                    if (i_req || d_req) begin
                        m_own_d  = (i_req && d_req) ? !m_last_d : d_req;
                        m_last_d = m_own_d;
                        m_we     = m_own_d && d_we;
                        m_base   = ((m_own_d ? d_addr : i_addr) / (LW * 4)) * (LW * 4);
                        m_beat   = 0;
                        m_phase  = 1;
                    end
                end
                1: if (mem_ack) begin
                    if (m_beat == LW - 1) begin
                        m_beat  = 0;
                        m_phase = 2;
                    end else begin
                        m_beat++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        bit burst, rv;
        burst = (m_phase == 1);
        rv    = burst && mem_ack && !m_we;
        chk("mem_req",      32'(mem_req),   32'(burst));
        chk("mem_we",       32'(mem_we),    32'(burst && m_we));
        chk("mem_addr",     mem_addr,       burst ? m_base + 32'(m_beat * 4) : 32'd0);
        chk("mem_wdata",    mem_wdata,      (burst && m_we) ? d_wdata : 32'd0);
        chk("i_rvalid",     32'(i_rvalid),  32'(rv && !m_own_d));
        chk("d_rvalid",     32'(d_rvalid),  32'(rv && m_own_d));
        chk("rdata",        rdata,          rv ? mem_rdata : 32'd0);
        chk("i_done",       32'(i_done),    32'(m_phase == 2 && !m_own_d));
        chk("d_done",       32'(d_done),    32'(m_phase == 2 && m_own_d));
        chk("beat",         32'(beat),      32'(m_beat));
        chk("conflict_cnt", conflict_cnt,   32'(m_cnt));
        s_mem_req = mem_req; s_mem_ack = mem_ack; s_mem_addr = mem_addr;
        s_mem_wdata = mem_wdata; s_i_rvalid = i_rvalid; s_d_rvalid = d_rvalid;
        s_i_done = i_done; s_d_done = d_done; s_beat = int'(beat); s_cnt = conflict_cnt;
    endtask

    // One clock: check mid-cycle, advance model on the edge, then drive the memory side
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
        cyc_n++;
        ack_tog   = !ack_tog;
        mem_ack   = (ack_mode == 0) ? 1'b1 : ack_tog;
        mem_rdata = 32'hA500_0000 ^ 32'(cyc_n * 32'h0001_0203);
        d_wdata   = wb_line[m_beat];
        if (s_i_done) i_req = 1'b0;
        if (s_d_done) d_req = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, input string nm);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            cyc();
            if (s_i_done || s_d_done) seen++;
        end
        chk(nm, 32'(seen), 32'(n));
    endtask

    logic [31:0] addr_seen [LW];
    logic [31:0] wd_seen   [LW];
    int          order [$];

    initial begin
        int k, nrv, other, done_at, last_ack, i_first, raised;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        for (int j = 0; j < LW; j++) wb_line[j] = 32'hD000_0000 + 32'(j) * 32'h111;
        @(posedge clk);
        model_step();
        #1;
        cyc(); cyc();
        chk("rst_mem_req", 32'(s_mem_req), 32'd0);
        chk("rst_cnt", s_cnt, 32'd0);
        rst = 1'b1;
        cyc();

        // I refill alone, ack every cycle
        i_addr = 32'h0000_1234; i_req = 1'b1; ack_mode = 0;
        k = 0; nrv = 0; other = 0; done_at = 0;
        for (int n = 1; n <= 16; n++) begin
            cyc();
            if (s_mem_req && s_mem_ack && k < LW) begin addr_seen[k] = s_mem_addr; k++; end
            if (s_i_rvalid) nrv++;
            if (s_d_rvalid || s_d_done) other++;
            if (s_i_done && done_at == 0) done_at = n;
        end
        chk("t1_done_cycle", 32'(done_at), 32'd10);
        chk("t1_addr0", addr_seen[0], 32'h0000_1220);
        chk("t1_addr1", addr_seen[1], 32'h0000_1224);
        chk("t1_addr7", addr_seen[7], 32'h0000_123C);
        chk("t1_rvalid_beats", 32'(nrv), 32'd8);
        chk("t1_d_quiet", 32'(other), 32'd0);

        // D write-back, ack every other cycle
        d_we = 1'b1; d_addr = 32'h8000_0040; d_req = 1'b1; ack_mode = 1;
        k = 0; nrv = 0; other = 0; done_at = 0; last_ack = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (s_mem_req && s_mem_ack && k < LW) begin
                addr_seen[k] = s_mem_addr; wd_seen[k] = s_mem_wdata; k++; last_ack = n;
            end
            if (s_d_rvalid) nrv++;
            if (s_i_rvalid || s_i_done) other++;
            if (s_d_done && done_at == 0) done_at = n;
        end
        chk("t2_acks", 32'(k), 32'd8);
        chk("t2_wdata0", wd_seen[0], 32'hD000_0000);
        chk("t2_wdata3", wd_seen[3], 32'hD000_0333);
        chk("t2_wdata7", wd_seen[7], 32'hD000_0777);
        chk("t2_addr3", addr_seen[3], 32'h8000_004C);
        chk("t2_no_rvalid", 32'(nrv), 32'd0);
        chk("t2_done_after_last", 32'(done_at), 32'(last_ack + 1));
        chk("t2_i_quiet", 32'(other), 32'd0);
        d_we = 1'b0; ack_mode = 0;

        // Ties after reset alternate starting with D
        rst = 1'b0; cyc(); cyc(); rst = 1'b1;
        i_addr = 32'h0000_2000; d_addr = 32'h0000_3000; i_req = 1'b1; d_req = 1'b1;
        k = 0;
        for (int n = 0; n < 120 && order.size() < 4; n++) begin
            cyc();
            if (s_mem_req && k == 0) begin chk("t3_cnt_first", s_cnt, 32'd1); k = 1; end
            if (s_d_done) order.push_back(1);
            if (s_i_done) begin
                order.push_back(0);
                if (order.size() == 2) begin i_req = 1'b1; d_req = 1'b1; end
            end
        end
        chk("t3_grants", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            chk("t3_g0_d", 32'(order[0]), 32'd1);
            chk("t3_g1_i", 32'(order[1]), 32'd0);
            chk("t3_g2_d", 32'(order[2]), 32'd1);
            chk("t3_g3_i", 32'(order[3]), 32'd0);
        end
        chk("t3_cnt_final", s_cnt, 32'd2);

        // Late I request during a D burst waits for IDLE
        d_addr = 32'h0000_4000; d_req = 1'b1;
        raised = 0; done_at = 0; i_first = 0; k = 0;
        for (int n = 1; n <= 60; n++) begin
            cyc();
            if (!raised && s_mem_req && s_beat == 3) begin
                i_req = 1'b1; i_addr = 32'h0000_5000; raised = 1;
            end
            if (s_d_done) done_at = n;
            if (s_mem_req && s_mem_addr == 32'h0000_5000 && i_first == 0) i_first = n;
            if (s_i_done) begin k = 1; break; end
        end
        chk("t4_gap", 32'(i_first - done_at), 32'd2);
        chk("t4_i_finished", 32'(k), 32'd1);

        // Reset in the middle of a burst
        i_addr = 32'h0000_6000; i_req = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (s_mem_req && s_beat == 2) break;
        end
        rst = 1'b0; i_req = 1'b0;
        cyc();
        chk("t5_beat3_seen", 32'(s_beat), 32'd3);
        cyc();
        chk("t5_req_dropped", 32'(s_mem_req), 32'd0);
        chk("t5_beat_zero", 32'(s_beat), 32'd0);
        chk("t5_no_done", 32'(s_i_done || s_d_done), 32'd0);
        chk("t5_cnt_cleared", s_cnt, 32'd0);
        rst = 1'b1; cyc();
        i_req = 1'b1; k = 0;
        for (int n = 0; n < 10 && k == 0; n++) begin
            cyc();
            if (s_mem_req) begin
                chk("t5_restart_beat", 32'(s_beat), 32'd0);
                chk("t5_restart_addr", s_mem_addr, 32'h0000_6000);
                k = 1;
            end
        end
        chk("t5_restarted", 32'(k), 32'd1);
        wait_dones(1, 20, "t5_finish");

        // Counter saturation
        force dut.cnt_q = 32'hFFFF_FFFE;
        m_cnt = 64'hFFFF_FFFE;
        cyc();
        release dut.cnt_q;
        cyc();
        chk("t6_preset", s_cnt, 32'hFFFF_FFFE);
        i_addr = 32'h0000_7000; d_addr = 32'h0000_7100; i_req = 1'b1; d_req = 1'b1;
        cyc(); cyc();
        chk("t6_sat1", s_cnt, 32'hFFFF_FFFF);
        wait_dones(2, 60, "t6_pair1");
        i_req = 1'b1; d_req = 1'b1;
        cyc(); cyc();
        chk("t6_sat2", s_cnt, 32'hFFFF_FFFF);
        wait_dones(2, 60, "t6_pair2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
